// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns, debounces press and release,
// and emits one key code plus a register-bank write strobe per keystroke.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV        = 16'd1000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] row_in,
    output logic [3:0] col_n,
    output logic [1:0] col_sel,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] wr_addr
);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    localparam logic [15:0] SCAN_LAST = SCAN_DIV - 16'd1;
    localparam logic [15:0] DEB_LAST  = DEBOUNCE_CYCLES - 16'd1;

    state_t      state_q, state_d;
    logic [3:0]  sync1_q, rs_q;
    logic [3:0]  pat_q, pat_d;
    logic [15:0] colTmr_q, colTmr_d;
    logic [15:0] dbCnt_q, dbCnt_d;
    logic [1:0]  colSel_q, colSel_d;
    logic [3:0]  keyCode_q, keyCode_d;
    logic        keyValid_q, keyValid_d;
    logic [1:0]  wrAddr_q, wrAddr_d;
    logic [1:0]  rowIdx;
    logic        scanWrap;

    function automatic logic [15:0] satInc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Several rows on one column resolve to the lowest-numbered row.
    always_comb begin
        rowIdx = 2'd0;
        if (pat_q[0])      rowIdx = 2'd0;
        else if (pat_q[1]) rowIdx = 2'd1;
        else if (pat_q[2]) rowIdx = 2'd2;
        else if (pat_q[3]) rowIdx = 2'd3;
    end

    assign scanWrap = (colTmr_q >= SCAN_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 4'd0;
            rs_q       <= 4'd0;
            state_q    <= SCAN;
            pat_q      <= 4'd0;
            colTmr_q   <= 16'd0;
            dbCnt_q    <= 16'd0;
            colSel_q   <= 2'd0;
            keyCode_q  <= 4'd0;
            keyValid_q <= 1'b0;
            wrAddr_q   <= 2'd0;
        end else begin
            sync1_q    <= row_in;
            rs_q       <= sync1_q;
            state_q    <= state_d;
            pat_q      <= pat_d;
            colTmr_q   <= colTmr_d;
            dbCnt_q    <= dbCnt_d;
            colSel_q   <= colSel_d;
            keyCode_q  <= keyCode_d;
            keyValid_q <= keyValid_d;
            wrAddr_q   <= wrAddr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        colTmr_d   = colTmr_q;
        dbCnt_d    = dbCnt_q;
        colSel_d   = colSel_q;
        keyCode_d  = keyCode_q;
        keyValid_d = 1'b0;
        wrAddr_d   = keyValid_q ? wrAddr_q + 2'd1 : wrAddr_q;

        // Disabled: keep walking the columns but never look at the rows.
        if (!ena) begin
            state_d = SCAN;
            dbCnt_d = 16'd0;
            if (scanWrap) begin
                colTmr_d = 16'd0;
                colSel_d = colSel_q + 2'd1;
            end else begin
                colTmr_d = satInc(colTmr_q);
            end
        end else begin
            case (state_q)
                SCAN: begin
                    if (rs_q != 4'd0) begin
                        pat_d   = rs_q;
                        dbCnt_d = 16'd0;
                        state_d = DEBOUNCE;
                    end else if (scanWrap) begin
                        colTmr_d = 16'd0;
                        colSel_d = colSel_q + 2'd1;
                    end else begin
                        colTmr_d = satInc(colTmr_q);
                    end
                end
                DEBOUNCE: begin
                    if (rs_q == pat_q) begin
                        if (dbCnt_q >= DEB_LAST) begin
                            state_d    = PRESSED;
                            keyValid_d = 1'b1;
                            keyCode_d  = {rowIdx, colSel_q};
                            dbCnt_d    = 16'd0;
                        end else begin
                            dbCnt_d = satInc(dbCnt_q);
                        end
                    end else begin
                        state_d  = SCAN;
                        dbCnt_d  = 16'd0;
                        colTmr_d = 16'd0;
                    end
                end
                PRESSED: begin
                    if (rs_q == 4'd0) begin
                        dbCnt_d = 16'd0;
                        state_d = RELEASE;
                    end
                end
                RELEASE: begin
                    if (rs_q != 4'd0) begin
                        state_d = PRESSED;
                        dbCnt_d = 16'd0;
                    end else if (dbCnt_q >= DEB_LAST) begin
                        state_d  = SCAN;
                        dbCnt_d  = 16'd0;
                        colTmr_d = 16'd0;
                        colSel_d = colSel_q + 2'd1;
                    end else begin
                        dbCnt_d = satInc(dbCnt_q);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_comb begin
        col_n    = ~(4'b0001 << colSel_q);
        key_held = (state_q == PRESSED) || (state_q == RELEASE);
    end

    assign col_sel   = colSel_q;
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign wr_addr   = wrAddr_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed keypad scenarios plus random row traffic,
// every output compared each cycle against a run-length model of the keypad.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DC = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [3:0] row_in;
    logic [3:0] col_n;
    logic [1:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [1:0] wr_addr;

    int testsRun    = 0;
    int testsFailed = 0;
    bit checkOn     = 0;
    int validCount  = 0;
    int dropCount   = 0;
    bit prevHeld    = 0;
    int validAddrQ[$];

    // Model: column position/age, candidate pattern with its match run,
    // and a zero-run counter while a key is down.
    int mS1, mRs, mCol, mAge, mCand, mMatch, mZero, mCode, mAddr;
    bit mDown, mValid;

    keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CYCLES(16'd3)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .row_in(row_in),
        .col_n(col_n), .col_sel(col_sel), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held), .wr_addr(wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lowestRow(input int rows);
        for (int i = 0; i < 4; i++)
            if (((rows >> i) & 1) == 1) return i;
        return 0;
    endfunction

    task automatic scanTick();
        mAge = mAge + 1;
        if (mAge == SD) begin
            mAge = 0;
            mCol = (mCol + 1) % 4;
        end
    endtask

    task automatic modelStep();
        if (!rst_n) begin
            mS1 = 0; mRs = 0; mCol = 0; mAge = 0; mCand = 0; mMatch = 0;
            mZero = 0; mCode = 0; mAddr = 0; mDown = 0; mValid = 0;
        end else begin
            if (mValid) mAddr = (mAddr + 1) % 4;
            mValid = 0;
            if (!ena) begin
                mCand = 0; mDown = 0; mZero = 0;
                scanTick();
            end else if (mDown) begin
                if (mRs == 0) begin
                    mZero = mZero + 1;
                    if (mZero == DC + 1) begin
                        mDown = 0; mZero = 0; mAge = 0;
                        mCol = (mCol + 1) % 4;
                    end
                end else begin
                    mZero = 0;
                end
            end else if (mCand != 0) begin
                if (mRs == mCand) begin
                    mMatch = mMatch + 1;
                    if (mMatch == DC + 1) begin
                        mValid = 1; mDown = 1; mZero = 0;
                        mCode = lowestRow(mCand) * 4 + mCol;
                        mCand = 0;
                    end
                end else begin
                    mCand = 0; mAge = 0;
                end
            end else if (mRs != 0) begin
                mCand = mRs; mMatch = 1;
            end else begin
                scanTick();
            end
            mRs = mS1;
            mS1 = int'(row_in);
        end
    endtask

    initial begin
        mS1 = 0; mRs = 0; mCol = 0; mAge = 0; mCand = 0; mMatch = 0;
        mZero = 0; mCode = 0; mAddr = 0; mDown = 0; mValid = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            modelStep();
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (checkOn) begin
                checkOutput("colSel", int'(col_sel), mCol);
                checkOutput("colN", int'(col_n), 15 - (1 << mCol));
                checkOutput("keyValid", int'(key_valid), int'(mValid));
                checkOutput("keyHeld", int'(key_held), int'(mDown));
                checkOutput("keyCode", int'(key_code), mCode);
                checkOutput("wrAddr", int'(wr_addr), mAddr);
            end
            if (key_valid) begin
                validCount++;
                validAddrQ.push_back(int'(wr_addr));
            end
            if (prevHeld && !key_held) dropCount++;
            prevHeld = key_held;
        end
    end

    task automatic applyStimulus(input logic [3:0] rows, input int cycles);
        row_in = rows;
        repeat (cycles) @(negedge clk);
        #1;
    endtask

    task automatic waitIdleCol(input int col);
        bit found = 0;
        for (int i = 0; i < 200; i++) begin
            if (mCol == col && mAge == 0 && mCand == 0 && !mDown) begin
                found = 1;
                break;
            end
            applyStimulus(4'd0, 1);
        end
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL waitIdleCol%0d: got timeout, expected idle column", col);
        end
    endtask

    task automatic pressKey(input int col, input logic [3:0] rows, input int expCode);
        waitIdleCol(col);
        applyStimulus(rows, 10);
        checkOutput("pressCode", int'(key_code), expCode);
        applyStimulus(4'd0, 8);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b0; row_in = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOn = 1;
        #1;
        checkOutput("rstColN", int'(col_n), 4'b1110);
        checkOutput("rstColSel", int'(col_sel), 0);
        checkOutput("rstKeyCode", int'(key_code), 0);
        checkOutput("rstValid", int'(key_valid), 0);
        checkOutput("rstHeld", int'(key_held), 0);
        checkOutput("rstWrAddr", int'(wr_addr), 0);

        // Idle scan and first column advance after reset.
        rst_n = 1'b1; ena = 1'b1;
        validCount = 0;
        applyStimulus(4'd0, 3);
        checkOutput("firstColHold", int'(col_sel), 0);
        applyStimulus(4'd0, 1);
        checkOutput("firstColAdv", int'(col_sel), 1);
        applyStimulus(4'd0, 28);
        checkOutput("idleValid", validCount, 0);

        // Clean press on column 1, row 2.
        waitIdleCol(1);
        checkOutput("preWrAddr", int'(wr_addr), 0);
        validCount = 0; dropCount = 0;
        applyStimulus(4'b0100, 20);
        checkOutput("pressHeld", int'(key_held), 1);
        applyStimulus(4'd0, 10);
        checkOutput("cleanValids", validCount, 1);
        checkOutput("cleanCode", int'(key_code), 4'h9);
        checkOutput("cleanWrAddr", int'(wr_addr), 1);
        checkOutput("cleanDrops", dropCount, 1);

        // Bouncing contact never qualifies.
        validCount = 0;
        repeat (3) begin
            applyStimulus(4'b0010, 2);
            applyStimulus(4'd0, 2);
        end
        applyStimulus(4'd0, 6);
        checkOutput("bounceValids", validCount, 0);
        checkOutput("bounceHeld", int'(key_held), 0);

        // Reset in the middle of debouncing discards the key.
        waitIdleCol(2);
        validCount = 0;
        applyStimulus(4'b1000, 4);
        rst_n = 1'b0;
        applyStimulus(4'b1000, 2);
        checkOutput("midRstColN", int'(col_n), 4'b1110);
        checkOutput("midRstWrAddr", int'(wr_addr), 0);
        checkOutput("midRstHeld", int'(key_held), 0);
        row_in = 4'd0;
        rst_n = 1'b1;
        applyStimulus(4'd0, 10);
        checkOutput("midRstValids", validCount, 0);

        // Multi-row resolution and write-address wrap over five keys.
        validAddrQ.delete();
        pressKey(3, 4'b1010, 4'h7);
        pressKey(0, 4'b0001, 4'h0);
        pressKey(1, 4'b0100, 4'h9);
        pressKey(2, 4'b1000, 4'hE);
        pressKey(1, 4'b0010, 4'h5);
        checkOutput("wrapCount", validAddrQ.size(), 5);
        if (validAddrQ.size() == 5) begin
            checkOutput("wrapAddr0", validAddrQ[0], 0);
            checkOutput("wrapAddr1", validAddrQ[1], 1);
            checkOutput("wrapAddr2", validAddrQ[2], 2);
            checkOutput("wrapAddr3", validAddrQ[3], 3);
            checkOutput("wrapAddr4", validAddrQ[4], 0);
        end

        // Dropping enable mid-debounce keeps code and address.
        waitIdleCol(0);
        validCount = 0;
        applyStimulus(4'b0001, 4);
        ena = 1'b0;
        applyStimulus(4'b0001, 1);
        checkOutput("enaHeld", int'(key_held), 0);
        checkOutput("enaValid", int'(key_valid), 0);
        checkOutput("enaKeyCode", int'(key_code), 4'h5);
        checkOutput("enaWrAddr", int'(wr_addr), 1);
        applyStimulus(4'd0, 3);
        ena = 1'b1;
        applyStimulus(4'd0, 6);
        checkOutput("enaValids", validCount, 0);

        // Release bounce yields one key and one release.
        waitIdleCol(0);
        validCount = 0; dropCount = 0;
        applyStimulus(4'b0001, 10);
        applyStimulus(4'd0, 2);
        applyStimulus(4'b0001, 1);
        applyStimulus(4'd0, 5);
        applyStimulus(4'd0, 6);
        checkOutput("relBounceValids", validCount, 1);
        checkOutput("relBounceDrops", dropCount, 1);

        // Random traffic with occasional enable drops and resets.
        repeat (400) begin
            int act;
            act = $urandom_range(0, 19);
            if (act == 0) begin
                ena = 1'b0;
                applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 6));
                ena = 1'b1;
            end else if (act == 1) begin
                rst_n = 1'b0;
                applyStimulus(4'($urandom_range(0, 15)), $urandom_range(1, 3));
                rst_n = 1'b1;
            end else if (act < 10) begin
                applyStimulus(4'd0, $urandom_range(1, 12));
            end else begin
                applyStimulus(4'($urandom_range(1, 15)), $urandom_range(1, 12));
            end
        end
        applyStimulus(4'd0, 20);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
